// File: rtl/fam_pkg.sv
// Shared types for the FAM edge dispatcher: edge record, 4-lane bundle and gather FSM states.
package fam_pkg;

  localparam int ADDRW = 16;
  localparam int WL    = 32;
  localparam int LANES = 4;
  localparam int SLOTS = LANES - 1;

  typedef struct packed {
    logic [ADDRW-1:0] src;
    logic [ADDRW-1:0] dst;
    logic [WL-1:0]    value;
  } edge_t;

  typedef struct packed {
    edge_t [LANES-1:0] lane;
    logic  [LANES-1:0] valid;
    logic              last;
  } bundle_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } gather_state_e;

endpackage

// File: rtl/fam_bundle_reg.sv
// Output bundle register: holds a bundle until the FAM consumes it; contents read as zero when empty.
module fam_bundle_reg
  import fam_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load_i,
  input  bundle_t bundle_i,
  input  logic    out_ready_i,
  output logic    out_valid_o,
  output bundle_t bundle_o
);

  logic    valid_q;
  bundle_t bundle_q;
  logic    consume;

  assign consume = valid_q & out_ready_i;

  // A load always wins over a consume, so load-and-consume keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (load_i) begin
      valid_q  <= 1'b1;
      bundle_q <= bundle_i;
    end else if (consume) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end
  end

  assign out_valid_o = valid_q;
  assign bundle_o    = bundle_q;

endmodule

// File: rtl/fam_edge_dispatcher.sv
// Packs a serial edge stream into 4-lane FAM bundles, flushing partial bundles on in_last.
// Optional FAM_EDGE_ZERO_DROP_EN: accepted zero-valued edges are counted but never occupy a lane.
module fam_edge_dispatcher
  import fam_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADDRW-1:0] in_src,
  input  logic [ADDRW-1:0] in_dst,
  input  logic [WL-1:0]    in_value,
  input  logic             in_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_last,
  output logic [ADDRW-1:0] src0,
  output logic [ADDRW-1:0] src1,
  output logic [ADDRW-1:0] src2,
  output logic [ADDRW-1:0] src3,
  output logic [ADDRW-1:0] dst0,
  output logic [ADDRW-1:0] dst1,
  output logic [ADDRW-1:0] dst2,
  output logic [ADDRW-1:0] dst3,
  output logic [WL-1:0]    value0,
  output logic [WL-1:0]    value1,
  output logic [WL-1:0]    value2,
  output logic [WL-1:0]    value3,
  output logic             valid0,
  output logic             valid1,
  output logic             valid2,
  output logic             valid3,
  output logic [31:0]      edge_count
);

  gather_state_e     state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        cnt_w;
  edge_t [SLOTS-1:0] slot_q;
  logic [31:0]       edge_count_q;

  edge_t             in_edge;
  logic              accept, drop, load;
  edge_t [LANES-1:0] lane_d;
  logic  [LANES-1:0] vld_d;
  bundle_t           bundle_d, bundle_q;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign in_edge  = '{src: in_src, dst: in_dst, value: in_value};
  assign cnt_w    = {1'b0, cnt_q};

`ifdef FAM_EDGE_ZERO_DROP_EN
  assign drop = (in_value == '0);
`else
  assign drop = 1'b0;
`endif

  // A dropped edge never fills the fourth lane, but its in_last still flushes.
  assign load = accept & (in_last | (~drop & (cnt_q == 2'd3)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = S_IDLE;
      cnt_d   = 2'd0;
    end else if (accept && !drop) begin
      state_d = S_FILL;
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      slot_q       <= '0;
      edge_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && !drop && !load) slot_q[cnt_q] <= in_edge;
      if (accept) edge_count_q <= edge_count_q + 32'd1;
    end
  end

  // Lanes below cnt come from the gather slots, lane cnt takes the incoming edge.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [2:0] IDX = 3'(i);
    logic from_slot, from_in;
    assign from_slot = (IDX < cnt_w);
    assign from_in   = (IDX == cnt_w) && !drop;
    assign vld_d[i]  = from_slot | from_in;
    if (i < SLOTS) begin : g_slot
      assign lane_d[i] = from_slot ? slot_q[i] : (from_in ? in_edge : '0);
    end else begin : g_tail
      assign lane_d[i] = from_in ? in_edge : '0;
    end
  end

  assign bundle_d = '{lane: lane_d, valid: vld_d, last: in_last};

  fam_bundle_reg u_bundle_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .bundle_i    (bundle_d),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .bundle_o    (bundle_q)
  );

  assign out_last   = bundle_q.last;
  assign src0       = bundle_q.lane[0].src;
  assign src1       = bundle_q.lane[1].src;
  assign src2       = bundle_q.lane[2].src;
  assign src3       = bundle_q.lane[3].src;
  assign dst0       = bundle_q.lane[0].dst;
  assign dst1       = bundle_q.lane[1].dst;
  assign dst2       = bundle_q.lane[2].dst;
  assign dst3       = bundle_q.lane[3].dst;
  assign value0     = bundle_q.lane[0].value;
  assign value1     = bundle_q.lane[1].value;
  assign value2     = bundle_q.lane[2].value;
  assign value3     = bundle_q.lane[3].value;
  assign valid0     = bundle_q.valid[0];
  assign valid1     = bundle_q.valid[1];
  assign valid2     = bundle_q.valid[2];
  assign valid3     = bundle_q.valid[3];
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_fam_edge_dispatcher.sv
// Scoreboard bench for fam_edge_dispatcher: queue-based packing model, decoupled bundle monitor.
module tb_fam_edge_dispatcher;
  import fam_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ADDRW-1:0] in_src = '0;
  logic [ADDRW-1:0] in_dst = '0;
  logic [WL-1:0]    in_value = '0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid, out_last;
  logic [ADDRW-1:0] src0, src1, src2, src3, dst0, dst1, dst2, dst3;
  logic [WL-1:0]    value0, value1, value2, value3;
  logic             valid0, valid1, valid2, valid3;
  logic [31:0]      edge_count;

  always #5 clk = ~clk;

  fam_edge_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_dst(in_dst), .in_value(in_value), .in_last(in_last),
    .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
    .src0(src0), .src1(src1), .src2(src2), .src3(src3),
    .dst0(dst0), .dst1(dst1), .dst2(dst2), .dst3(dst3),
    .value0(value0), .value1(value1), .value2(value2), .value3(value3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .edge_count(edge_count)
  );

  int          checks = 0;
  int          errors = 0;
  bundle_t     expq[$];
  edge_t       pend[$];
  int unsigned exp_cnt = 0;
  bit          load_flag = 1'b0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input bundle_t act, input bundle_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t dut_bundle();
    bundle_t b;
    b.lane[0] = '{src: src0, dst: dst0, value: value0};
    b.lane[1] = '{src: src1, dst: dst1, value: value1};
    b.lane[2] = '{src: src2, dst: dst2, value: value2};
    b.lane[3] = '{src: src3, dst: dst3, value: value3};
    b.valid   = {valid3, valid2, valid1, valid0};
    b.last    = out_last;
    return b;
  endfunction

  // Reference model: collect edges, emit a bundle at 4 edges or on last.
  task automatic model_accept();
    bundle_t b;
    bit      dropped;
`ifdef FAM_EDGE_ZERO_DROP_EN
    dropped = (in_value == 0);
`else
    dropped = 1'b0;
`endif
    exp_cnt++;
    if (!dropped) pend.push_back('{src: in_src, dst: in_dst, value: in_value});
    if (in_last || pend.size() == LANES) begin
      b = '0;
      foreach (pend[k]) begin
        b.lane[k]  = pend[k];
        b.valid[k] = 1'b1;
      end
      b.last = in_last;
      expq.push_back(b);
      pend.delete();
      load_flag = 1'b1;
    end
  endtask

  task automatic model_reset();
    pend.delete();
    expq.delete();
    exp_cnt   = 0;
    load_flag = 1'b0;
  endtask

  task automatic monitor();
    bundle_t prev;
    bit      hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold) begin
          chk("hold_valid", out_valid, 1);
          chkb("hold_stable", dut_bundle(), prev);
        end
        chk("in_ready", in_ready, 64'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
          if (expq.size() == 0) chk("bundle_expected", out_valid, 0);
          else chkb("bundle", dut_bundle(), expq.pop_front());
        end
        hold = out_valid && !out_ready;
        prev = dut_bundle();
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  endtask

  task automatic tick(output bit acc);
    @(negedge clk);
    if (load_flag) chk("valid_latency", out_valid, 1);
    acc = rst_n && in_valid && in_ready;
    @(posedge clk);
    load_flag = 1'b0;
    if (acc) model_accept();
    #1;
  endtask

  task automatic send(input logic [ADDRW-1:0] s, input logic [ADDRW-1:0] d,
                      input logic [WL-1:0] v, input logic l);
    bit a = 1'b0;
    in_valid = 1'b1; in_src = s; in_dst = d; in_value = v; in_last = l;
    for (int k = 0; k < 64 && !a; k++) tick(a);
    if (!a) chk("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    repeat (n) tick(a);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_valid"}, {valid3, valid2, valid1, valid0}, 0);
    chk({tag, "_lanes"}, {src0, dst3, value0, value3}, 0);
    chk({tag, "_edge_count"}, edge_count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    bit a;
    fork
      monitor();
      ready_driver();
    join_none

    #2 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two full bundles back to back
    for (int i = 1; i <= 8; i++) send(16'(i), 16'(i + 100), 32'(i), 1'b0);
    idle(2);
    chk("cnt_8", edge_count, 64'(exp_cnt));

    // Partial flush on last
    for (int i = 1; i <= 6; i++) send(16'(i + 10), 16'(i + 20), 32'(i), i == 6);
    idle(2);
    chk("cnt_flush", edge_count, 64'(exp_cnt));

    // Backpressure: held bundle blocks the next edge for 5 cycles
    ready_mode = 2;
    idle(1);
    for (int i = 1; i <= 4; i++) send(16'(i + 30), 16'(i + 40), 32'(i + 50), 1'b0);
    in_valid = 1'b1; in_src = 16'h99; in_dst = 16'h98; in_value = 32'h97; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(a);
      chk("bp_no_accept", a, 0);
    end
    chk("bp_in_ready", in_ready, 0);
    ready_mode = 0;
    send(16'h99, 16'h98, 32'h97, 1'b1);
    idle(2);

    // Single edge with last from IDLE
    rst_n = 1'b0; #1 model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    send(16'h7, 16'h8, 32'd42, 1'b1);
    idle(2);
    chk("cnt_single", edge_count, 1);

    // Mid-stream reset: with two pending edges, then with a held bundle
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        ready_mode = 2;
        idle(1);
        for (int i = 0; i < 4; i++) send(16'(i), 16'(i), 32'(i + 60), 1'b0);
        idle(1);
      end else begin
        send(16'h1, 16'h2, 32'd3, 1'b0);
        send(16'h4, 16'h5, 32'd6, 1'b0);
      end
      rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      model_reset();
      ready_mode = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 11; i <= 14; i++) send(16'(i), 16'(i + 1), 32'(i), 1'b0);
      idle(2);
      chk("cnt_after_rst", edge_count, 4);
    end

    // Zero-valued edges, then a zero-valued last
    send(16'h1, 16'h1, 32'd3, 1'b0);
    send(16'h2, 16'h2, 32'd0, 1'b0);
    send(16'h3, 16'h3, 32'd5, 1'b0);
    send(16'h4, 16'h4, 32'd0, 1'b0);
    send(16'h5, 16'h5, 32'd7, 1'b0);
    send(16'h6, 16'h6, 32'd9, 1'b0);
    idle(2);
    chk("cnt_zero", edge_count, 64'(exp_cnt));
    send(16'h7, 16'h7, 32'd0, 1'b1);
    idle(2);

    // Randomized traffic with random backpressure and gaps
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(16'($urandom), 16'($urandom),
           ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
           $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    ready_mode = 0;
    in_valid = 1'b0;
    for (int k = 0; k < 50 && expq.size() != 0; k++) tick(a);
    chk("drain_empty", 64'(expq.size()), 0);
    chk("cnt_final", edge_count, 64'(exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fam_edge_dispatcher.md
# fam_edge_dispatcher

Upstream feeder for the FAM edge-processing array. Accepts a serial edge stream (one edge/cycle, valid/ready), packs edges into 4-lane bundles, and presents each bundle on the FAM edge lanes (srcN/dstN/valueN/validN, N=0..3) from a registered output stage. Partial bundles are flushed at partition end (in_last), so the FAM never waits on a stalled partial group.

## Interface
- ADDRW, 16, vertex address width (src/dst)
- WL, 32, edge value width
- LANES, 4, lanes per bundle; fixed at 4 to match FAM lanes 0..3
- clk  input  1  clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream edge valid
- in_ready  output  1  dispatcher accepts edge this cycle
- in_src  input  ADDRW  edge source vertex
- in_dst  input  ADDRW  edge destination vertex
- in_value  input  WL  edge value
- in_last  input  1  last edge of partition; forces flush
- out_ready  input  1  FAM consumes bundle (driven from FAM ena)
- out_valid  output  1  bundle register holds a bundle
- out_last  output  1  bundle contains the partition's last edge
- src0..src3  output  ADDRW each  lane source addresses
- dst0..dst3  output  ADDRW each  lane destination addresses
- value0..value3  output  WL each  lane values
- valid0..valid3  output  1 each  lane occupied
- edge_count  output  32  total accepted edges since reset, wraps at 2^32

## Operation
- Gather buffer: 3 slots + fill counter cnt (0..3). State IDLE (cnt=0) / FILL (cnt=1..3).
- Edge accepted when in_valid & in_ready. in_ready = ~out_valid | out_ready (combinational).
- Accept with cnt<3 and in_last=0: edge written to slot cnt; cnt+1.
- Accept with cnt=3, or with in_last=1: slots 0..cnt-1 plus incoming edge loaded into output register lanes 0..cnt; cnt -> 0 (IDLE); out_valid set; out_last = in_last.
- Lane fill order strict: lane 0 first. Unused lanes: validN=0, srcN/dstN/valueN=0.
- Bundle register cleared (out_valid=0) when out_valid & out_ready and no new bundle loads the same cycle; load-and-consume same cycle replaces contents, out_valid stays 1.
- in_last with cnt=0 yields a single-lane bundle (valid0 only).
- edge_count increments by 1 per accepted edge (including dropped edges, see Configuration).
- Reset (any time): cnt=0, out_valid=0, out_last=0, all lane outputs 0, validN=0, edge_count=0; pending edges discarded. in_ready=1 during/after reset.

## Timing
- Bundle-completing edge accepted in cycle N -> out_valid=1 in N+1.
- Non-completing edges: no output change.
- Sustained throughput: 1 edge/cycle, 1 bundle per 4 cycles when out_ready=1.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0; outputs held stable until consumed.
- in_src/dst/value/last sampled only on acceptance; ignored otherwise.

## Configuration
- FAM_EDGE_ZERO_DROP_EN defined: accepted edges with in_value==0 are not written to any lane (cnt unchanged). If such an edge has in_last=1, pending slots are still flushed with out_last=1; if cnt=0 then, a bundle with all validN=0 and out_last=1 is emitted.
- Undefined: zero-valued edges treated as ordinary edges.

## Structure
- Shared package fam_pkg: ADDRW, WL, LANES constants; edge_t struct {src, dst, value}; bundle_t {edge_t lane[LANES], logic [LANES-1:0] valid, logic last}.
- One sub-module: fam_bundle_reg (output register with out_valid/out_ready hold logic); gather buffer and counter in the top.

## Test plan
- Reset then 8 edges back-to-back (values 1..8), out_ready=1 -> two bundles, lanes values 1..4 and 5..8, all validN=1, each out_valid 1 cycle after 4th/8th acceptance.
- 6 edges, 6th with in_last=1 -> bundle {1..4}, then bundle lanes0-1 = {5,6}, valid=4'b0011, out_last=1, lanes 2-3 zero.
- Bundle pending, out_ready=0 for 5 cycles -> in_ready=0, outputs stable; out_ready=1 -> consumed, in_ready=1 same cycle.
- Single edge with in_last=1 from IDLE -> valid=4'b0001, out_last=1; edge_count=1.
- Assert rst_n low with cnt=2 and bundle held -> all outputs 0 immediately; next 4 edges form a clean bundle.
- With FAM_EDGE_ZERO_DROP_EN: values 3,0,5,0,7,9 -> bundle {3,5,7,9}; edge_count=6.
